// File: rtl/vvadd_mem_pkg.sv
// rtl/vvadd_mem_pkg.sv - shared constants, channel enum and request layout for vvadd_mem_server
package vvadd_mem_pkg;

  localparam int ADDR_W = 7;
  localparam int DATA_W = 32;
  // DEPTH must equal 2**ADDR_W so addresses wrap inside their own channel region
  localparam int DEPTH  = 128;
  localparam int REQ_W  = ADDR_W + DATA_W + 2;
  localparam int NUM_CH = 3;
  // flat store index is {channel[1:0], addr}
  localparam int IDX_W  = ADDR_W + 2;

  localparam int RD_BIT   = 0;
  localparam int WR_BIT   = 1;
  localparam int DATA_LSB = 2;
  localparam int ADDR_LSB = 34;

  typedef enum logic [1:0] {
    CH_A = 2'd0,
    CH_B = 2'd1,
    CH_C = 2'd2
  } ch_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              wr;
    logic              rd;
  } req_t;

  function automatic req_t unpack_req(input logic [REQ_W-1:0] i_raw);
    req_t v_req;
    v_req.rd   = i_raw[RD_BIT];
    v_req.wr   = i_raw[WR_BIT];
    v_req.data = i_raw[DATA_LSB +: DATA_W];
    v_req.addr = i_raw[ADDR_LSB +: ADDR_W];
    return v_req;
  endfunction

endpackage

// File: rtl/rr_arbiter3.sv
// rtl/rr_arbiter3.sv - 3-way round-robin arbiter, one-hot grant, pointer advances past each winner
module rr_arbiter3
  import vvadd_mem_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] i_elig,
  output logic [2:0] o_grant
);

  ch_e r_ptr;
  ch_e w_ptr_nxt;

  // pointer register; holds when nothing is granted
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= CH_A;
    end else begin
      r_ptr <= w_ptr_nxt;
    end
  end

  // priority search starting at the pointer, then pick the channel after the winner
  always_comb begin
    o_grant   = 3'b000;
    w_ptr_nxt = r_ptr;
    case (r_ptr)
      CH_B: begin
        if      (i_elig[1]) o_grant = 3'b010;
        else if (i_elig[2]) o_grant = 3'b100;
        else if (i_elig[0]) o_grant = 3'b001;
      end
      CH_C: begin
        if      (i_elig[2]) o_grant = 3'b100;
        else if (i_elig[0]) o_grant = 3'b001;
        else if (i_elig[1]) o_grant = 3'b010;
      end
      default: begin
        if      (i_elig[0]) o_grant = 3'b001;
        else if (i_elig[1]) o_grant = 3'b010;
        else if (i_elig[2]) o_grant = 3'b100;
      end
    endcase
    case (o_grant)
      3'b001:  w_ptr_nxt = CH_B;
      3'b010:  w_ptr_nxt = CH_C;
      3'b100:  w_ptr_nxt = CH_A;
      default: w_ptr_nxt = r_ptr;
    endcase
  end

endmodule

// File: rtl/vvadd_mem_server.sv
// rtl/vvadd_mem_server.sv - three-channel single-ported word store for vvadd128 (optional MEM_CLEAR_EN power-on clear sweep)
module vvadd_mem_server
  import vvadd_mem_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [REQ_W-1:0]  mem__req_A,
  input  logic              mem__req_A_vld,
  output logic              mem__req_A_rdy,
  output logic [DATA_W-1:0] mem__resp_A,
  output logic              mem__resp_A_vld,
  input  logic              mem__resp_A_rdy,
  input  logic [REQ_W-1:0]  mem__req_B,
  input  logic              mem__req_B_vld,
  output logic              mem__req_B_rdy,
  output logic [DATA_W-1:0] mem__resp_B,
  output logic              mem__resp_B_vld,
  input  logic              mem__resp_B_rdy,
  input  logic [REQ_W-1:0]  mem__req_C,
  input  logic              mem__req_C_vld,
  output logic              mem__req_C_rdy,
  output logic [DATA_W-1:0] mem__resp_C,
  output logic              mem__resp_C_vld,
  input  logic              mem__resp_C_rdy
`ifdef MEM_CLEAR_EN
  ,
  output logic              clr_busy
`endif
);

  localparam int MEM_WORDS = NUM_CH * DEPTH;

  req_t              w_req [NUM_CH];
  logic [NUM_CH-1:0] w_req_vld;
  logic [NUM_CH-1:0] w_resp_rdy;
  logic [NUM_CH-1:0] w_slot_free;
  logic [NUM_CH-1:0] w_elig;
  logic [NUM_CH-1:0] w_grant;
  logic              w_svc_en;
  logic              w_any_grant;

  logic [DATA_W-1:0] r_resp_data [NUM_CH];
  logic              r_resp_vld  [NUM_CH];

  req_t              w_sel_req;
  ch_e               w_sel_ch;
  logic [IDX_W-1:0]  w_acc_idx;
  logic [DATA_W-1:0] w_rd_data;

  logic              w_mem_we;
  logic [IDX_W-1:0]  w_mem_widx;
  logic [DATA_W-1:0] w_mem_wdata;
  logic [DATA_W-1:0] r_mem [MEM_WORDS];

  assign w_req[0] = unpack_req(mem__req_A);
  assign w_req[1] = unpack_req(mem__req_B);
  assign w_req[2] = unpack_req(mem__req_C);

  assign w_req_vld  = {mem__req_C_vld, mem__req_B_vld, mem__req_A_vld};
  assign w_resp_rdy = {mem__resp_C_rdy, mem__resp_B_rdy, mem__resp_A_rdy};

  // eligibility uses only the response slot state, never the grant, so rdy has no loop through vld
  assign w_elig = w_req_vld & w_slot_free & {NUM_CH{w_svc_en}};

  rr_arbiter3 u_arb (
    .clk     (clk),
    .rst     (rst),
    .i_elig  (w_elig),
    .o_grant (w_grant)
  );

  assign mem__req_A_rdy = w_grant[0];
  assign mem__req_B_rdy = w_grant[1];
  assign mem__req_C_rdy = w_grant[2];
  assign w_any_grant    = |w_grant;

  // steer the granted channel's request onto the single store port
  always_comb begin
    w_sel_req = w_req[0];
    w_sel_ch  = CH_A;
    if (w_grant[1]) begin
      w_sel_req = w_req[1];
      w_sel_ch  = CH_B;
    end
    if (w_grant[2]) begin
      w_sel_req = w_req[2];
      w_sel_ch  = CH_C;
    end
  end

  assign w_acc_idx = {w_sel_ch, w_sel_req.addr};
  // asynchronous read gives the pre-write contents for read-modify-write
  assign w_rd_data = r_mem[w_acc_idx];

`ifdef MEM_CLEAR_EN
  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_SERVE = 1'b1
  } clr_state_e;

  clr_state_e       r_state;
  clr_state_e       w_state_nxt;
  logic [IDX_W-1:0] r_clr_idx;
  logic [IDX_W-1:0] w_clr_idx_nxt;

  // clear-sweep state and index; any reset restarts the sweep at index 0
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_CLEAR;
      r_clr_idx <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_idx <= w_clr_idx_nxt;
    end
  end

  // sweep owns the write port until the last index is cleared, then requests do
  always_comb begin
    w_state_nxt   = r_state;
    w_clr_idx_nxt = r_clr_idx;
    w_mem_we      = 1'b0;
    w_mem_widx    = w_acc_idx;
    w_mem_wdata   = w_sel_req.data;
    case (r_state)
      ST_CLEAR: begin
        w_mem_we      = ~rst;
        w_mem_widx    = r_clr_idx;
        w_mem_wdata   = '0;
        w_clr_idx_nxt = r_clr_idx + 1'b1;
        if (r_clr_idx == IDX_W'(MEM_WORDS - 1)) begin
          w_state_nxt = ST_SERVE;
        end
      end
      default: begin
        w_mem_we = w_any_grant & w_sel_req.wr;
      end
    endcase
  end

  assign w_svc_en = ~rst & (r_state == ST_SERVE);
  assign clr_busy = (r_state == ST_CLEAR);
`else
  assign w_svc_en    = ~rst;
  assign w_mem_we    = w_any_grant & w_sel_req.wr;
  assign w_mem_widx  = w_acc_idx;
  assign w_mem_wdata = w_sel_req.data;
`endif

  // single write port; contents are deliberately left out of reset
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_widx] <= w_mem_wdata;
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_resp
    assign w_slot_free[k] = ~r_resp_vld[k] | w_resp_rdy[k];

    // response slot: reload on grant (even while draining), otherwise clear on handshake
    always_ff @(posedge clk) begin
      if (rst) begin
        r_resp_vld[k]  <= 1'b0;
        r_resp_data[k] <= '0;
      end else if (w_grant[k]) begin
        r_resp_vld[k]  <= 1'b1;
        r_resp_data[k] <= w_sel_req.rd ? w_rd_data : '0;
      end else if (r_resp_vld[k] && w_resp_rdy[k]) begin
        r_resp_vld[k]  <= 1'b0;
      end
    end
  end

  assign mem__resp_A     = r_resp_data[0];
  assign mem__resp_B     = r_resp_data[1];
  assign mem__resp_C     = r_resp_data[2];
  assign mem__resp_A_vld = r_resp_vld[0];
  assign mem__resp_B_vld = r_resp_vld[1];
  assign mem__resp_C_vld = r_resp_vld[2];

endmodule

// File: tb/tb_vvadd_mem_server.sv
// tb/tb_vvadd_mem_server.sv - randomized bench for vvadd_mem_server against a behavioural model (MEM_CLEAR_EN aware)
module tb_vvadd_mem_server;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [40:0] req      [3];
  logic        req_vld  [3];
  logic        req_rdy  [3];
  logic [31:0] resp     [3];
  logic        resp_vld [3];
  logic        resp_rdy [3];
`ifdef MEM_CLEAR_EN
  logic        clr_busy;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // behavioural model state
  logic [31:0] m_mem  [384];
  logic        m_vld  [3];
  logic [31:0] m_data [3];
  int          m_ptr;
  int          obs_g;

  always #5 clk = ~clk;

  vvadd_mem_server dut (
    .clk             (clk),
    .rst             (rst),
    .mem__req_A      (req[0]),
    .mem__req_A_vld  (req_vld[0]),
    .mem__req_A_rdy  (req_rdy[0]),
    .mem__resp_A     (resp[0]),
    .mem__resp_A_vld (resp_vld[0]),
    .mem__resp_A_rdy (resp_rdy[0]),
    .mem__req_B      (req[1]),
    .mem__req_B_vld  (req_vld[1]),
    .mem__req_B_rdy  (req_rdy[1]),
    .mem__resp_B     (resp[1]),
    .mem__resp_B_vld (resp_vld[1]),
    .mem__resp_B_rdy (resp_rdy[1]),
    .mem__req_C      (req[2]),
    .mem__req_C_vld  (req_vld[2]),
    .mem__req_C_rdy  (req_rdy[2]),
    .mem__resp_C     (resp[2]),
    .mem__resp_C_vld (resp_vld[2]),
    .mem__resp_C_rdy (resp_rdy[2])
`ifdef MEM_CLEAR_EN
    ,
    .clr_busy        (clr_busy)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [40:0] mk(input logic [6:0] a, input logic [31:0] d,
                                     input logic wr, input logic rd);
    return {a, d, wr, rd};
  endfunction

  task automatic idle();
    for (int k = 0; k < 3; k++) begin
      req[k]      = '0;
      req_vld[k]  = 1'b0;
      resp_rdy[k] = 1'b1;
    end
  endtask

  task automatic issue(input int k, input logic [6:0] a, input logic [31:0] d,
                       input logic wr, input logic rd);
    req[k]     = mk(a, d, wr, rd);
    req_vld[k] = 1'b1;
  endtask

  // one clock: check grant and responses against the model, then advance the model
  task automatic tick();
    int          g;
    int          idx;
    logic [31:0] old;
    logic [6:0]  a;
    #1;
    g = -1;
    for (int o = 0; o < 3; o++) begin
      int k;
      k = (m_ptr + o) % 3;
      if (g < 0 && req_vld[k] && (!m_vld[k] || resp_rdy[k])) g = k;
    end
    obs_g = -1;
    for (int k = 0; k < 3; k++) begin
      if (req_rdy[k] === 1'b1) obs_g = k;
      check($sformatf("req_rdy[%0d]", k), 32'(req_rdy[k]), 32'(k == g));
      check($sformatf("resp_vld[%0d]", k), 32'(resp_vld[k]), 32'(m_vld[k]));
      if (m_vld[k]) check($sformatf("resp[%0d]", k), resp[k], m_data[k]);
    end
    for (int k = 0; k < 3; k++) begin
      if (k != g && m_vld[k] && resp_rdy[k]) m_vld[k] = 1'b0;
    end
    if (g >= 0) begin
      a   = req[g][40:34];
      idx = g * 128 + int'(a);
      old = m_mem[idx];
      if (req[g][1]) m_mem[idx] = req[g][33:2];
      m_data[g] = req[g][0] ? old : 32'h0;
      m_vld[g]  = 1'b1;
      m_ptr     = (g + 1) % 3;
    end
    @(negedge clk);
  endtask

`ifdef MEM_CLEAR_EN
  task automatic sweep_check();
    for (int k = 0; k < 3; k++) issue(k, 7'd0, 32'h0, 1'b0, 1'b1);
    for (int i = 0; i < 384; i++) begin
      #1;
      check("clr_busy_high", 32'(clr_busy), 32'd1);
      check("clr_rdy_low", {29'd0, req_rdy[2], req_rdy[1], req_rdy[0]}, 32'd0);
      @(negedge clk);
    end
    idle();
    #1;
    check("clr_busy_done", 32'(clr_busy), 32'd0);
    for (int i = 0; i < 384; i++) m_mem[i] = 32'h0;
    @(negedge clk);
  endtask
`endif

  task automatic do_reset();
    rst = 1'b1;
    for (int k = 0; k < 3; k++) issue(k, 7'd3, 32'h0, 1'b0, 1'b1);
    @(negedge clk);
    @(negedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rst_rdy[%0d]", k), 32'(req_rdy[k]), 32'd0);
      check($sformatf("rst_vld[%0d]", k), 32'(resp_vld[k]), 32'd0);
      check($sformatf("rst_resp[%0d]", k), resp[k], 32'd0);
    end
    idle();
    rst   = 1'b0;
    m_ptr = 0;
    for (int k = 0; k < 3; k++) begin
      m_vld[k]  = 1'b0;
      m_data[k] = 32'h0;
    end
`ifdef MEM_CLEAR_EN
    sweep_check();
`endif
  endtask

  task automatic random_traffic(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      for (int k = 0; k < 3; k++) begin
        logic [6:0] a;
        a = ($urandom_range(0, 1) == 1) ? 7'($urandom_range(0, 3)) : 7'($urandom_range(0, 127));
        req[k]      = mk(a, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        req_vld[k]  = ($urandom_range(0, 3) != 0);
        resp_rdy[k] = ($urandom_range(0, 3) != 0);
      end
      tick();
    end
    idle();
    tick();
  endtask

  initial begin
    int g0;
    int cnt [3];
    logic [31:0] held;
    idle();
    @(negedge clk);

`ifdef MEM_CLEAR_EN
    // reset in the middle of a sweep must restart the full count
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 100; i++) @(negedge clk);
`endif
    do_reset();

`ifdef MEM_CLEAR_EN
    issue(1, 7'd64, 32'h0, 1'b0, 1'b1);
    tick();
    idle();
    check("clr_B64", resp[1], 32'h0);
    tick();
`endif

    // prefill every word with a lone streaming channel
    for (int k = 0; k < 3; k++) begin
      for (int a = 0; a < 128; a++) begin
        idle();
        issue(k, 7'(a), $urandom, 1'b1, 1'b0);
        tick();
      end
    end
    idle();
    tick();

    // write A[5], B[5], then read them back
    issue(0, 7'd5, 32'h11, 1'b1, 1'b0);
    tick();
    idle();
    check("wrA_vld", 32'(resp_vld[0]), 32'd1);
    check("wrA_resp", resp[0], 32'h0);
    issue(1, 7'd5, 32'h22, 1'b1, 1'b0);
    tick();
    idle();
    check("wrB_resp", resp[1], 32'h0);
    issue(0, 7'd5, 32'h0, 1'b0, 1'b1);
    tick();
    idle();
    check("rdA5", resp[0], 32'h11);
    issue(1, 7'd5, 32'h0, 1'b0, 1'b1);
    tick();
    idle();
    check("rdB5", resp[1], 32'h22);
    tick();

    // all three streaming: strict A,B,C rotation
    for (int k = 0; k < 3; k++) issue(k, 7'(k + 10), 32'h0, 1'b0, 1'b1);
    tick();
    g0 = obs_g;
    for (int i = 1; i < 9; i++) begin
      tick();
      check("rr_order", 32'(obs_g), 32'((g0 + i) % 3));
    end
    idle();
    tick();

    // A's consumer stalls: A is not regranted, its response holds, B and C keep flowing
    resp_rdy[0] = 1'b0;
    for (int k = 0; k < 3; k++) issue(k, 7'd5, 32'h0, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) cnt[k] = 0;
    for (int i = 0; i < 7; i++) begin
      tick();
      if (obs_g >= 0) cnt[obs_g]++;
    end
    held = resp[0];
    check("stall_held_val", held, 32'h11);
    for (int i = 0; i < 4; i++) begin
      tick();
      if (obs_g >= 0) cnt[obs_g]++;
      check("stall_hold", resp[0], held);
    end
    check("stall_A_grants", 32'(cnt[0]), 32'd1);
    check("stall_BC_served", 32'(cnt[1] >= 3 && cnt[2] >= 3), 32'd1);
    idle();
    tick();
    tick();

    // back-to-back write then read of C[127]
    issue(2, 7'd127, 32'hDEADBEEF, 1'b1, 1'b0);
    tick();
    issue(2, 7'd127, 32'h0, 1'b0, 1'b1);
    tick();
    idle();
    check("rawC127", resp[2], 32'hDEADBEEF);
    issue(0, 7'd127, 32'h0, 1'b0, 1'b1);
    issue(1, 7'd127, 32'h0, 1'b0, 1'b1);
    tick();
    tick();
    idle();
    tick();

    // read-modify-write and no-op requests on A[0]
    issue(0, 7'd0, 32'h5, 1'b1, 1'b0);
    tick();
    issue(0, 7'd0, 32'h9, 1'b1, 1'b1);
    tick();
    check("rmw_old", resp[0], 32'h5);
    issue(0, 7'd0, 32'h0, 1'b0, 1'b1);
    tick();
    check("rmw_new", resp[0], 32'h9);
    issue(0, 7'd0, 32'h77, 1'b0, 1'b0);
    tick();
    check("nop_resp", resp[0], 32'h0);
    issue(0, 7'd0, 32'h0, 1'b0, 1'b1);
    tick();
    idle();
    check("nop_untouched", resp[0], 32'h9);
    tick();

    random_traffic(3000);

    // reset with traffic in flight, then carry on
    random_traffic(50);
    do_reset();
    random_traffic(500);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
